// File: rtl/wb_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wb_port_arbiter                                                 |
// | Desc     : Round-robin arbiter sharing the register-file write port among  |
// |            NUM_REQ writeback sources; registered write stage, saturating   |
// |            commit counter. Define WB_BYPASS_EN for read forwarding ports.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module wb_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64,
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*REG_AW-1:0] req_reg,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      regWrite,
    output logic [REG_AW-1:0]         write_reg,
    output logic [DATA_W-1:0]         write_data,
    output logic [CNT_W-1:0]          wb_count
`ifdef WB_BYPASS_EN
    ,
    input  logic [REG_AW-1:0]         read_reg1,
    input  logic [REG_AW-1:0]         read_reg2,
    input  logic [DATA_W-1:0]         rf_data1,
    input  logic [DATA_W-1:0]         rf_data2,
    output logic [DATA_W-1:0]         fwd_data1,
    output logic [DATA_W-1:0]         fwd_data2
`endif
);

    localparam int                 c_ptr_w    = $clog2(NUM_REQ);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(NUM_REQ - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [CNT_W-1:0]   c_cnt_max  = '1;
    localparam logic [CNT_W-1:0]   c_cnt_one  = CNT_W'(1);

    logic [c_ptr_w-1:0] r_rr_ptr;
    logic               r_we;
    logic [REG_AW-1:0]  r_reg;
    logic [DATA_W-1:0]  r_data;
    logic [CNT_W-1:0]   r_cnt;

    logic [NUM_REQ-1:0] w_upper_mask;
    logic [NUM_REQ-1:0] w_upper_req;
    logic [NUM_REQ-1:0] w_scan_req;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_xfer;
    logic [c_ptr_w-1:0] w_grant_idx;
    logic [c_ptr_w-1:0] w_ptr_next;
    logic [REG_AW-1:0]  w_sel_reg;
    logic [DATA_W-1:0]  w_sel_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_upper_mask
            assign w_upper_mask[gi] = (c_ptr_w'(gi) >= r_rr_ptr);
        end
    endgenerate

    // Requests at or above the pointer win first; otherwise wrap to the lowest
    // valid index. x & -x isolates the lowest set bit of the chosen set.
    assign w_upper_req = req_valid & w_upper_mask;
    assign w_scan_req  = (|w_upper_req) ? w_upper_req : req_valid;
    assign w_grant     = reset ? '0 : (w_scan_req & (~w_scan_req + NUM_REQ'(1)));
    assign w_xfer      = |w_grant;
    assign req_ready   = w_grant;

    always_comb begin
        w_grant_idx = '0;
        w_sel_reg   = '0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_grant_idx = c_ptr_w'(i);
                w_sel_reg   = req_reg[i*REG_AW +: REG_AW];
                w_sel_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_ptr_next = (w_grant_idx == c_ptr_last) ? '0 : (w_grant_idx + c_ptr_one);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= '0;
            r_we     <= 1'b0;
            r_reg    <= '0;
            r_data   <= '0;
            r_cnt    <= '0;
        end else begin
            // r0 writes complete the handshake but never reach the register file
            r_we <= w_xfer && (w_sel_reg != '0);
            if (w_xfer) begin
                r_rr_ptr <= w_ptr_next;
                r_reg    <= w_sel_reg;
                r_data   <= w_sel_data;
                if ((w_sel_reg != '0) && (r_cnt != c_cnt_max)) begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end
        end
    end

    assign regWrite   = r_we;
    assign write_reg  = r_reg;
    assign write_data = r_data;
    assign wb_count   = r_cnt;

`ifdef WB_BYPASS_EN
    // The register file shows this write only after the next edge; forward it now.
    assign fwd_data1 = (r_we && (r_reg == read_reg1) && (read_reg1 != '0)) ? r_data : rf_data1;
    assign fwd_data2 = (r_we && (r_reg == read_reg2) && (read_reg2 != '0)) ? r_data : rf_data2;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_wb_port_arbiter                                              |
// | Desc     : Scoreboard bench for wb_port_arbiter (CNT_W=4 to reach the      |
// |            saturation point); covers WB_BYPASS_EN when defined.            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_wb_port_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 64;
    localparam int REG_AW  = 5;
    localparam int CNT_W   = 4;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*REG_AW-1:0] req_reg;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      regWrite;
    logic [REG_AW-1:0]         write_reg;
    logic [DATA_W-1:0]         write_data;
    logic [CNT_W-1:0]          wb_count;
`ifdef WB_BYPASS_EN
    logic [REG_AW-1:0]         read_reg1, read_reg2;
    logic [DATA_W-1:0]         rf_data1, rf_data2, fwd_data1, fwd_data2;
`endif

    wb_port_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data),
        .req_ready(req_ready), .regWrite(regWrite), .write_reg(write_reg),
        .write_data(write_data), .wb_count(wb_count)
`ifdef WB_BYPASS_EN
        , .read_reg1(read_reg1), .read_reg2(read_reg2),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
    );

    typedef struct {
        logic [NUM_REQ-1:0] grant;
        logic [REG_AW-1:0]  rg;
        logic [DATA_W-1:0]  data;
        logic               we;
        logic [CNT_W-1:0]   cnt;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             pend;
    bit               have_pend;
    int               n_checks;
    int               n_errors;
    logic [CNT_W-1:0] model_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic set_src(input int s, input logic [REG_AW-1:0] r, input logic [DATA_W-1:0] d);
        req_reg[s*REG_AW +: REG_AW]  = r;
        req_data[s*DATA_W +: DATA_W] = d;
    endtask

    // Expected outcome of the grant this cycle; count follows a saturating model.
    task automatic push(input int s, input logic [REG_AW-1:0] r, input logic [DATA_W-1:0] d);
        exp_t e;
        if (r != '0 && model_cnt != 4'hF) model_cnt = model_cnt + 4'd1;
        e.grant = NUM_REQ'(1) << s;
        e.rg    = r;
        e.data  = d;
        e.we    = (r != '0);
        e.cnt   = model_cnt;
        exp_q.push_back(e);
    endtask

    // Monitor: checks last cycle's transfer in the output stage, then this cycle's grant.
    always @(negedge clk) begin
        if (reset) begin
            have_pend = 1'b0;
        end else begin
            if (have_pend) begin
                check("out_we",    64'(regWrite),   64'(pend.we));
                check("out_reg",   64'(write_reg),  64'(pend.rg));
                check("out_data",  write_data,      pend.data);
                check("out_count", 64'(wb_count),   64'(pend.cnt));
                have_pend = 1'b0;
            end else begin
                check("idle_we", 64'(regWrite), 64'd0);
            end
            if (exp_q.size() != 0) begin
                pend = exp_q.pop_front();
                check("grant", 64'(req_ready), 64'(pend.grant));
                have_pend = 1'b1;
            end else if (req_ready != '0) begin
                check("unexpected_grant", 64'(req_ready), 64'd0);
            end
        end
    end

    initial begin
        #100000;
        n_errors++;
        $display("FAIL timeout: bench did not complete");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        n_checks = 0; n_errors = 0; model_cnt = '0; have_pend = 1'b0;
        reset = 1'b1; req_valid = '0; req_reg = '0; req_data = '0;
`ifdef WB_BYPASS_EN
        read_reg1 = '0; read_reg2 = '0; rf_data1 = '0; rf_data2 = '0;
`endif
        repeat (2) @(posedge clk);
        #1 req_valid = 4'hF;
        #1 check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_we", 64'(regWrite), 64'd0);
        check("rst_count", 64'(wb_count), 64'd0);
        req_valid = '0;
        @(posedge clk); #1 reset = 1'b0;

        // Idle after reset
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_ready", 64'(req_ready), 64'd0);
            check("idle_count", 64'(wb_count), 64'd0);
        end

        // Single request from source 1
        @(posedge clk); #1;
        set_src(1, 5'd7, 64'hDEAD); req_valid = 4'b0010; push(1, 5'd7, 64'hDEAD);
        @(posedge clk); #1 req_valid = '0;

        // Reset pulse so the round-robin sequence starts from pointer 0
        @(posedge clk); #1 reset = 1'b1; model_cnt = '0;
        @(posedge clk); #1 reset = 1'b0;

        // Round robin with all sources held valid
        @(posedge clk); #1;
        for (int s = 0; s < NUM_REQ; s++) set_src(s, 5'(s + 1), 64'h1000 + 64'(s));
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            push(k % 4, 5'((k % 4) + 1), 64'h1000 + 64'(k % 4));
            @(posedge clk); #1;
        end
        req_valid = '0;

        // r0 write: accepted, not committed, not counted
        @(posedge clk); #1;
        set_src(0, 5'd0, 64'h5); req_valid = 4'b0001; push(0, 5'd0, 64'h5);
        @(posedge clk); #1 req_valid = '0;

        // Two sources, same register, back to back: grant order 2 then 3
        @(posedge clk); #1;
        set_src(2, 5'd9, 64'hA); set_src(3, 5'd9, 64'hB); req_valid = 4'b1100;
        push(2, 5'd9, 64'hA);
        @(posedge clk); #1 req_valid = 4'b1000; push(3, 5'd9, 64'hB);
        @(posedge clk); #1 req_valid = '0;

        // Counter runs to 15 and saturates
        @(posedge clk); #1 req_valid = 4'b0010;
        for (int k = 0; k < 7; k++) begin
            set_src(1, 5'd2, 64'h200 + 64'(k)); push(1, 5'd2, 64'h200 + 64'(k));
            @(posedge clk); #1;
        end
        req_valid = '0;

        // Reset mid-cycle after a transfer: pointer was left at 2
        @(posedge clk); #1;
        set_src(1, 5'd3, 64'h77); set_src(3, 5'd4, 64'h88); req_valid = 4'b0010;
        push(1, 5'd3, 64'h77);
        @(posedge clk); #1 req_valid = '0;
        #1 check("pre_rst_we", 64'(regWrite), 64'd1);
        #1 reset = 1'b1; model_cnt = '0; req_valid = 4'b1010;
        #1 check("mid_rst_we", 64'(regWrite), 64'd0);
        check("mid_rst_reg", 64'(write_reg), 64'd0);
        check("mid_rst_data", write_data, 64'd0);
        check("mid_rst_count", 64'(wb_count), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        push(1, 5'd3, 64'h77);
        @(posedge clk); #1 req_valid = '0;

`ifdef WB_BYPASS_EN
        @(posedge clk); #1;
        set_src(0, 5'd5, 64'hAA); req_valid = 4'b0001; push(0, 5'd5, 64'hAA);
        @(posedge clk); #1 req_valid = '0;
        read_reg1 = 5'd5; rf_data1 = 64'h0; read_reg2 = 5'd6; rf_data2 = 64'h66;
        #1 check("fwd1_hit", fwd_data1, 64'hAA);
        check("fwd2_miss", fwd_data2, 64'h66);
        read_reg1 = 5'd0; rf_data1 = 64'h11;
        #1 check("fwd1_r0", fwd_data1, 64'h11);
        @(posedge clk); #1 read_reg1 = 5'd5; rf_data1 = 64'h22;
        #1 check("fwd1_stale", fwd_data1, 64'h22);
`endif

        repeat (3) @(posedge clk);
        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
